ctrl_refresh_sched: RTL and testbench

Refresh scheduler for the DDR4 controller. It generates the periodic refresh requirement, postpones refreshes while read/write traffic is active, and reclaims the DDR command bus to issue precharge-all followed by REF. It holds off the activate/CAS path (`ref_hold`) while it owns the bus, and tells the open-row tracker to forget every open row (`bank_clear`).

---
 rtl/ctrl_refresh_sched.sv | 154 +++++++++++++++
 tb/tb_ctrl_refresh_sched.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_refresh_sched.sv
// DDR4 refresh scheduler: counts owed refreshes, postpones them under traffic,
// and reclaims the command bus for precharge-all followed by REF.
module ctrl_refresh_sched #(
    parameter int T_REFI       = 6240,
    parameter int T_RFC        = 280,
    parameter int T_RP         = 11,
    parameter int MAX_POSTPONE = 8,
    parameter int CNT_W        = 16
) (
    input  logic       CK_t,
    input  logic       reset_n,
    input  logic       rw_idle,
    input  logic       banks_open,
    input  logic       cmd_bus_busy,
    output logic       ref_hold,
    output logic       prea_rdy,
    output logic       ref_rdy,
    output logic       bank_clear,
    output logic       ref_busy,
    output logic [3:0] pending_cnt,
    output logic       ref_overflow
);

    typedef enum logic [2:0] {
        REF_IDLE,
        REF_DRAIN,
        REF_PREA,
        REF_TRP,
        REF_CMD,
        REF_TRFC
    } ref_state_e;

    localparam logic [CNT_W-1:0] REFI_LAST = CNT_W'(T_REFI - 1);
    localparam logic [CNT_W-1:0] RFC_LAST  = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       PEND_MAX  = 4'(MAX_POSTPONE);

    ref_state_e       state_q, state_d;
    logic [CNT_W-1:0] refi_q, refi_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [3:0]       pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             prea_q, prea_d;
    logic             ref_q, ref_d;
    logic             tick;
    logic             urgent;

    assign tick   = (refi_q == REFI_LAST);
    assign refi_d = tick ? '0 : refi_q + CNT_ONE;
    assign urgent = (pend_q == PEND_MAX);

    always_comb begin : fsm_comb
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_d = state_q;
        dly_d   = dly_q;
        prea_d  = 1'b0;
        ref_d   = 1'b0;
        case (state_q)
            REF_IDLE: begin
                if (((pend_q != 4'd0) && rw_idle) || urgent) begin
                    state_d = REF_DRAIN;
                end
            end
            REF_DRAIN: begin
                if (rw_idle) begin
                    state_d = banks_open ? REF_PREA : REF_CMD;
                end
            end
            REF_PREA: begin
                if (!cmd_bus_busy) begin
                    prea_d  = 1'b1;
                    dly_d   = '0;
                    state_d = REF_TRP;
                end
            end
            REF_TRP: begin
                if (dly_q == RP_LAST) begin
                    state_d = REF_CMD;
                end else begin
                    dly_d = dly_q + CNT_ONE;
                end
            end
            REF_CMD: begin
                if (!cmd_bus_busy) begin
                    ref_d   = 1'b1;
                    dly_d   = '0;
                    state_d = REF_TRFC;
                end
            end
            REF_TRFC: begin
                if (dly_q == RFC_LAST) begin
                    state_d = REF_IDLE;
                end else begin
                    dly_d = dly_q + CNT_ONE;
                end
            end
            default: state_d = REF_IDLE;
        endcase
    end

    // A tick and an issued REF in the same cycle cancel out.
    always_comb begin : pend_comb
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tick && !ref_d) begin
            if (urgent) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 4'd1;
            end
        end else if (ref_d && !tick && (pend_q != 4'd0)) begin
            pend_d = pend_q - 4'd1;
        end
        busy_d = (state_d != REF_IDLE);
        hold_d = (state_d != REF_IDLE) || (pend_d == PEND_MAX);
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= REF_IDLE;
            refi_q  <= '0;
            dly_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            prea_q  <= 1'b0;
            ref_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            state_q <= state_d;
            refi_q  <= refi_d;
            dly_q   <= dly_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            prea_q  <= prea_d;
            ref_q   <= ref_d;
        end
    end

    assign ref_hold     = hold_q;
    assign prea_rdy     = prea_q;
    assign bank_clear   = prea_q;
    assign ref_rdy      = ref_q;
    assign ref_busy     = busy_q;
    assign pending_cnt  = pend_q;
    assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_ctrl_refresh_sched.sv
// Bench for ctrl_refresh_sched: directed scenarios plus random traffic, all
// compared cycle by cycle against a timestamp-based reference model.
module tb_ctrl_refresh_sched;

    localparam int T_REFI = 100;
    localparam int T_RFC  = 20;
    localparam int T_RP   = 4;
    localparam int MAXP   = 8;

    logic       CK_t = 1'b0;
    logic       reset_n;
    logic       rw_idle;
    logic       banks_open;
    logic       cmd_bus_busy;
    logic       ref_hold;
    logic       prea_rdy;
    logic       ref_rdy;
    logic       bank_clear;
    logic       ref_busy;
    logic [3:0] pending_cnt;
    logic       ref_overflow;

    int vectors     = 0;
    int miscompares = 0;

    ctrl_refresh_sched #(
        .T_REFI      (T_REFI),
        .T_RFC       (T_RFC),
        .T_RP        (T_RP),
        .MAX_POSTPONE(MAXP),
        .CNT_W       (16)
    ) dut (
        .CK_t        (CK_t),
        .reset_n     (reset_n),
        .rw_idle     (rw_idle),
        .banks_open  (banks_open),
        .cmd_bus_busy(cmd_bus_busy),
        .ref_hold    (ref_hold),
        .prea_rdy    (prea_rdy),
        .ref_rdy     (ref_rdy),
        .bank_clear  (bank_clear),
        .ref_busy    (ref_busy),
        .pending_cnt (pending_cnt),
        .ref_overflow(ref_overflow)
    );

    always #5 CK_t = ~CK_t;

    logic [9:0] dut_vec;
    assign dut_vec = {ref_hold, prea_rdy, ref_rdy, bank_clear, ref_busy, pending_cnt, ref_overflow};

    // Reference model: a refresh "job" tracked by the edge numbers at which
    // its precharge and REF were issued, rather than by a state encoding.
    int         m_cyc, m_owed, m_pre_at, m_ref_at;
    bit         m_ovf, m_job, m_drained, m_need_pre;
    logic [9:0] exp_vec;

    task automatic model_reset();
        m_cyc      = 0;
        m_owed     = 0;
        m_ovf      = 1'b0;
        m_job      = 1'b0;
        m_drained  = 1'b0;
        m_need_pre = 1'b0;
        m_pre_at   = -1;
        m_ref_at   = -1;
        exp_vec    = '0;
    endtask

    task automatic model_step();
        bit issued;
        bit tick;
        issued = 1'b0;
        m_cyc++;
        if (!m_job) begin
            if ((m_owed > 0 && rw_idle) || m_owed == MAXP) begin
                m_job     = 1'b1;
                m_drained = 1'b0;
                m_pre_at  = -1;
                m_ref_at  = -1;
            end
        end else if (!m_drained) begin
            if (rw_idle) begin
                m_drained  = 1'b1;
                m_need_pre = banks_open;
            end
        end else if (m_need_pre && m_pre_at < 0) begin
            if (!cmd_bus_busy) m_pre_at = m_cyc;
        end else if (m_ref_at < 0) begin
            if (!cmd_bus_busy && (!m_need_pre || m_cyc > m_pre_at + T_RP)) begin
                m_ref_at = m_cyc;
                issued   = 1'b1;
            end
        end else if (m_cyc >= m_ref_at + T_RFC) begin
            m_job = 1'b0;
        end
        tick = (m_cyc % T_REFI == 0);
        if (tick && !issued) begin
            if (m_owed == MAXP) m_ovf = 1'b1;
            else m_owed++;
        end else if (issued && !tick) begin
            m_owed--;
        end
        exp_vec = {m_job || (m_owed == MAXP), m_pre_at == m_cyc, m_ref_at == m_cyc,
                   m_pre_at == m_cyc, m_job, 4'(m_owed), m_ovf};
    endtask

    task automatic step();
        @(posedge CK_t);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        rw_idle      = 1'b0;
        banks_open   = 1'b0;
        cmd_bus_busy = 1'b0;
        repeat (2) @(posedge CK_t);
        @(negedge CK_t);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        rw_idle      = 1'b1;
        banks_open   = 1'b1;
        cmd_bus_busy = 1'b0;
        repeat (3) @(posedge CK_t);
        #1;
        vectors++;
        if (dut_vec !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b want=%b", dut_vec, 10'b0);
        end
        @(negedge CK_t);
        reset_n = 1'b1;
        model_reset();
        for (int c = 1; c <= 5; c++) begin
            step();
            vectors++;
            if (dut_vec !== 10'b0) begin
                miscompares++;
                $display("FAIL post_reset_quiet cyc=%0d got=%b want=%b", c, dut_vec, 10'b0);
            end
        end
    endtask

    task automatic test_idle_refresh();
        int ref_cyc;
        int prea_seen;
        ref_cyc   = -1;
        prea_seen = 0;
        do_reset();
        rw_idle = 1'b1;
        for (int c = 1; c <= 130; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL idle_model cyc=%0d got=%b want=%b", c, dut_vec, exp_vec);
            end
            if (ref_rdy === 1'b1 && ref_cyc < 0) ref_cyc = c;
            if (prea_rdy === 1'b1) prea_seen++;
            if (c == 102 || c == 103) begin
                vectors++;
                if (pending_cnt !== ((c == 102) ? 4'd1 : 4'd0)) begin
                    miscompares++;
                    $display("FAIL idle_pending cyc=%0d got=%0d", c, pending_cnt);
                end
            end
            if (c == 122 || c == 123) begin
                vectors++;
                if (ref_busy !== (c == 122)) begin
                    miscompares++;
                    $display("FAIL idle_busy_window cyc=%0d got=%b", c, ref_busy);
                end
            end
        end
        vectors++;
        if (ref_cyc != 103) begin
            miscompares++;
            $display("FAIL idle_ref_cycle got=%0d want=103", ref_cyc);
        end
        vectors++;
        if (prea_seen != 0) begin
            miscompares++;
            $display("FAIL idle_no_prea got=%0d want=0", prea_seen);
        end
    endtask

    task automatic test_open_banks();
        int prea_cyc;
        int clr_cyc;
        int ref_cyc;
        int hold_drops;
        prea_cyc   = -1;
        clr_cyc    = -1;
        ref_cyc    = -1;
        hold_drops = 0;
        do_reset();
        rw_idle    = 1'b1;
        banks_open = 1'b1;
        for (int c = 1; c <= 130; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL banks_model cyc=%0d got=%b want=%b", c, dut_vec, exp_vec);
            end
            if (prea_rdy === 1'b1 && prea_cyc < 0) prea_cyc = c;
            if (bank_clear === 1'b1 && clr_cyc < 0) clr_cyc = c;
            if (ref_rdy === 1'b1 && ref_cyc < 0) ref_cyc = c;
            if (prea_rdy === 1'b1) banks_open = 1'b0;
            if (c >= 101 && c <= 127 && ref_hold !== 1'b1) hold_drops++;
        end
        vectors++;
        if (prea_cyc != 103 || clr_cyc != 103) begin
            miscompares++;
            $display("FAIL banks_prea_clear prea=%0d clear=%0d want=103", prea_cyc, clr_cyc);
        end
        vectors++;
        if (ref_cyc != 103 + T_RP + 1) begin
            miscompares++;
            $display("FAIL banks_ref_cycle got=%0d want=%0d", ref_cyc, 103 + T_RP + 1);
        end
        vectors++;
        if (hold_drops != 0) begin
            miscompares++;
            $display("FAIL banks_hold_low got=%0d cycles want=0", hold_drops);
        end
    endtask

    task automatic test_postpone_overflow();
        int nrefs;
        int last_ref;
        int close_pairs;
        int zero_cyc;
        nrefs       = 0;
        last_ref    = -1;
        close_pairs = 0;
        zero_cyc    = -1;
        do_reset();
        for (int c = 1; c <= 1200; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL postpone_model cyc=%0d got=%b want=%b", c, dut_vec, exp_vec);
            end
            if (c == 799 || c == 800) begin
                vectors++;
                if (ref_hold !== (c == 800) || pending_cnt !== ((c == 800) ? 4'd8 : 4'd7)) begin
                    miscompares++;
                    $display("FAIL urgent_entry cyc=%0d hold=%b pend=%0d", c, ref_hold, pending_cnt);
                end
            end
            if (c == 899 || c == 900) begin
                vectors++;
                if (ref_overflow !== (c == 900) || pending_cnt !== 4'd8) begin
                    miscompares++;
                    $display("FAIL overflow_set cyc=%0d ovf=%b pend=%0d", c, ref_overflow, pending_cnt);
                end
            end
            if (c > 900 && ref_rdy === 1'b1) begin
                if (last_ref > 0 && c - last_ref < T_RFC + 1) close_pairs++;
                last_ref = c;
                nrefs++;
            end
            if (c > 900 && zero_cyc < 0 && pending_cnt === 4'd0) zero_cyc = c;
            if (c == 900) rw_idle = 1'b1;
        end
        vectors++;
        if (nrefs < MAXP || close_pairs != 0) begin
            miscompares++;
            $display("FAIL drain_refs got=%0d close=%0d want>=%0d close=0", nrefs, close_pairs, MAXP);
        end
        vectors++;
        if (zero_cyc < 0) begin
            miscompares++;
            $display("FAIL drain_to_zero got=never want=pending 0");
        end
        vectors++;
        if (ref_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky got=%b want=1", ref_overflow);
        end
    endtask

    task automatic test_bus_contention();
        int k;
        int ref_cyc;
        int nref;
        k       = int'($urandom_range(1, 5));
        ref_cyc = -1;
        nref    = 0;
        do_reset();
        rw_idle = 1'b1;
        for (int c = 1; c <= 130; c++) begin
            cmd_bus_busy = (c >= 103 && c < 103 + k);
            step();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL bus_model cyc=%0d got=%b want=%b", c, dut_vec, exp_vec);
            end
            if (ref_rdy === 1'b1) begin
                nref++;
                if (ref_cyc < 0) ref_cyc = c;
            end
        end
        cmd_bus_busy = 1'b0;
        vectors++;
        if (ref_cyc != 103 + k || nref != 1) begin
            miscompares++;
            $display("FAIL bus_delay k=%0d got=cyc %0d x%0d want=cyc %0d x1", k, ref_cyc, nref, 103 + k);
        end
    endtask

    task automatic test_reset_mid();
        int ref_cyc;
        ref_cyc = -1;
        do_reset();
        rw_idle = 1'b1;
        for (int c = 1; c <= 110; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL midrst_pre cyc=%0d got=%b want=%b", c, dut_vec, exp_vec);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (dut_vec !== 10'b0) begin
            miscompares++;
            $display("FAIL midrst_async got=%b want=%b", dut_vec, 10'b0);
        end
        repeat (2) @(posedge CK_t);
        @(negedge CK_t);
        reset_n = 1'b1;
        model_reset();
        for (int c = 1; c <= 110; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL midrst_post cyc=%0d got=%b want=%b", c, dut_vec, exp_vec);
            end
            if (ref_rdy === 1'b1 && ref_cyc < 0) ref_cyc = c;
        end
        vectors++;
        if (ref_cyc != 103) begin
            miscompares++;
            $display("FAIL midrst_first_ref got=%0d want=103", ref_cyc);
        end
    endtask

    task automatic test_random();
        int p_idle;
        int p_busy;
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            p_idle = int'($urandom_range(0, 100));
            p_busy = int'($urandom_range(0, 60));
            for (int c = 0; c < 200; c++) begin
                rw_idle      = (int'($urandom_range(0, 99)) < p_idle);
                banks_open   = ($urandom_range(0, 1) == 1);
                cmd_bus_busy = (int'($urandom_range(0, 99)) < p_busy);
                step();
                vectors++;
                if (dut_vec !== exp_vec) begin
                    miscompares++;
                    $display("FAIL random_model blk=%0d cyc=%0d got=%b want=%b", blk, m_cyc, dut_vec, exp_vec);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_refresh();
        test_open_banks();
        test_postpone_overflow();
        test_bus_contention();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
